// File: rtl/sel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sel_pkg
//  Purpose  : Shared constants and state encoding for the select-line
//             receive encoder (sel_encoder) and its index encoder.
//  Revision : 1.0  initial release
// ============================================================================
package sel_pkg;

    // Bus geometry
    localparam int SEL_LINES = 16;
    localparam int IDX_W     = 4;

    // Idle pattern of the active-low select bus: no line asserted
    localparam logic [SEL_LINES-1:0] SEL_NONE = 16'hFFFF;

    // Receiver FSM state encoding
    typedef logic [1:0] sel_state_t;

    localparam sel_state_t ST_IDLE    = 2'd0;
    localparam sel_state_t ST_QUAL    = 2'd1;
    localparam sel_state_t ST_HOLD    = 2'd2;
    localparam sel_state_t ST_RELEASE = 2'd3;

endpackage : sel_pkg
`default_nettype wire

// File: rtl/sel_encoder_onehot_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_encoder
//  Purpose  : Combinational encoder for a 16-bit active-low select pattern.
//             Returns the index of the lowest-numbered low bit and, when
//             MULTI_EN is set, flags patterns with two or more low bits.
//  Ports    : i_sel_n  [15:0] active-low pattern (all ones = nothing asserted)
//             o_idx    [3:0]  lowest-numbered asserted line (0 if none)
//             o_multi         two or more lines asserted (0 if MULTI_EN = 0)
//  Revision : 1.0  initial release
// ============================================================================
module onehot_encoder
    import sel_pkg::*;
#(
    parameter bit MULTI_EN = 1'b0
) (
    input  logic [SEL_LINES-1:0] i_sel_n,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_multi
);

    // Scan from the top down so the lowest-numbered asserted line wins.
    always_comb begin
        o_idx = '0;
        for (int i = SEL_LINES - 1; i >= 0; i--) begin
            if (!i_sel_n[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    generate
        if (MULTI_EN) begin : g_multi
            logic [SEL_LINES-1:0] w_hot;
            assign w_hot = ~i_sel_n;
            // Clearing the lowest set bit leaves something only if a
            // second line is also asserted.
            assign o_multi = |(w_hot & (w_hot - {{(SEL_LINES-1){1'b0}}, 1'b1}));
        end else begin : g_no_multi
            assign o_multi = 1'b0;
        end
    endgenerate

endmodule : onehot_encoder
`default_nettype wire

// File: rtl/sel_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : sel_encoder
//  Purpose  : Receive side of the 16-line active-low select scanner. Samples
//             the select bus, qualifies a pattern for STABLE_CYCLES
//             consecutive cycles, encodes the asserted line and presents it
//             with a VALID/ACK handshake, then waits for the bus to release
//             before arming again.
//  Ports    : CLK          clock, rising edge
//             CLRBAR       synchronous reset, active-high
//             SEL   [15:0] select lines, active-low (16'hFFFF = none)
//             ACK          consumer accepts the presented index
//             IDX   [3:0]  encoded index of the captured line
//             VALID        IDX/ERR valid
//             ERR          captured pattern had more than one line low
//             BUSY         receiver not idle
//  Config   : SEL_ERR_CHECK_EN - when defined, ERR reports multi-hot
//             captures; otherwise ERR is held at 0.
//  Revision : 1.0  initial release
// ============================================================================
module sel_encoder
    import sel_pkg::*;
#(
    parameter int STABLE_CYCLES = 3     // legal range 1..15
) (
    input  logic                 CLK,
    input  logic                 CLRBAR,
    input  logic [SEL_LINES-1:0] SEL,
    input  logic                 ACK,
    output logic [IDX_W-1:0]     IDX,
    output logic                 VALID,
    output logic                 ERR,
    output logic                 BUSY
);

    localparam logic [3:0] c_stable = 4'(STABLE_CYCLES);

`ifdef SEL_ERR_CHECK_EN
    localparam bit c_multi_en = 1'b1;
`else
    localparam bit c_multi_en = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SEL_LINES-1:0] sel_q;
    sel_state_t           state_q, state_d;
    logic [3:0]           cnt_q,   cnt_d;
    logic [SEL_LINES-1:0] ref_q,   ref_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic                 err_q,   err_d;
    logic                 valid_q, valid_d;

    logic                 w_capture;
    logic                 w_ack_taken;
    logic [3:0]           w_cnt_inc;
    logic [IDX_W-1:0]     w_enc_idx;
    logic                 w_enc_multi;

    // cnt only increments while below c_stable (<= 15), so it cannot wrap.
    assign w_cnt_inc = cnt_q + 4'd1;

    // ------------------------------------------------------------------
    // Qualification FSM: next state, match counter and reference pattern
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ref_d       = ref_q;
        w_capture   = 1'b0;
        w_ack_taken = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel_q != SEL_NONE) begin
                    ref_d = sel_q;
                    cnt_d = 4'd1;
                    if (c_stable == 4'd1) begin
                        state_d   = ST_HOLD;
                        w_capture = 1'b1;
                    end else begin
                        state_d = ST_QUAL;
                    end
                end
            end

            ST_QUAL: begin
                if (sel_q == SEL_NONE) begin
                    state_d = ST_IDLE;
                end else if (sel_q != ref_q) begin
                    // Pattern moved: restart qualification from the new value.
                    ref_d = sel_q;
                    cnt_d = 4'd1;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == c_stable) begin
                        state_d   = ST_HOLD;
                        w_capture = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (ACK) begin
                    state_d     = ST_RELEASE;
                    w_ack_taken = 1'b1;
                end
            end

            ST_RELEASE: begin
                // Wait for the bus to go idle so a held line is not re-captured.
                if (sel_q == SEL_NONE) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The encoder sees ref_d so a single-cycle qualification (IDLE straight
    // to HOLD) encodes the pattern being captured on this edge.
    onehot_encoder #(
        .MULTI_EN (c_multi_en)
    ) u_onehot_encoder (
        .i_sel_n  (ref_d),
        .o_idx    (w_enc_idx),
        .o_multi  (w_enc_multi)
    );

    // ------------------------------------------------------------------
    // Output registers: loaded on capture, frozen through HOLD
    // ------------------------------------------------------------------
    always_comb begin
        idx_d   = idx_q;
        err_d   = err_q;
        valid_d = valid_q;

        if (w_capture) begin
            idx_d   = w_enc_idx;
            err_d   = w_enc_multi;
            valid_d = 1'b1;
        end else if (w_ack_taken) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLRBAR) begin
            sel_q   <= SEL_NONE;
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ref_q   <= SEL_NONE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sel_q   <= SEL;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign IDX   = idx_q;
    assign ERR   = err_q;
    assign VALID = valid_q;
    assign BUSY  = (state_q != ST_IDLE);

endmodule : sel_encoder
`default_nettype wire

// File: tb/tb_sel_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sel_encoder
//  Purpose  : Self-checking bench for sel_encoder (STABLE_CYCLES = 3).
//             Stimulus pushes the expected index/error/arrival cycle of each
//             capture into a queue; a monitor pops and compares on every
//             rising edge of VALID.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sel_encoder;

    localparam int STABLE = 3;

`ifdef SEL_ERR_CHECK_EN
    localparam logic C_ERR_MULTI = 1'b1;
`else
    localparam logic C_ERR_MULTI = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        CLRBAR;
    logic [15:0] SEL;
    logic        ACK;
    logic [3:0]  IDX;
    logic        VALID;
    logic        ERR;
    logic        BUSY;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0] idx;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    sel_encoder #(
        .STABLE_CYCLES (STABLE)
    ) dut (
        .CLK    (CLK),
        .CLRBAR (CLRBAR),
        .SEL    (SEL),
        .ACK    (ACK),
        .IDX    (IDX),
        .VALID  (VALID),
        .ERR    (ERR),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Monitor: every VALID rise must match the oldest expectation
    // ------------------------------------------------------------------
    logic prev_valid = 1'b0;

    always @(negedge CLK) begin
        if (VALID === 1'b1 && prev_valid !== 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got IDX=%h ERR=%b at cycle %0d, none expected",
                         IDX, ERR, cyc);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                if (IDX !== x.idx || ERR !== x.err || cyc != x.cyc) begin
                    n_err++;
                    $display("FAIL capture: got IDX=%h ERR=%b cycle %0d, expected IDX=%h ERR=%b cycle %0d",
                             IDX, ERR, cyc, x.idx, x.err, x.cyc);
                end
            end
        end
        prev_valid = VALID;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (VALID !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        chk("valid_rise", int'(VALID === 1'b1), 1);
    endtask

    // Drive a pattern; VALID is due STABLE+1 edges later.
    task automatic capture(input logic [15:0] s, input logic [3:0] i, input logic e);
        exp_t x;
        SEL   = s;
        x.idx = i;
        x.err = e;
        x.cyc = cyc + STABLE + 1;
        exp_q.push_back(x);
        wait_valid();
    endtask

    task automatic do_ack();
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("valid_after_ack", int'(VALID), 0);
        chk("busy_in_release", int'(BUSY), 1);
    endtask

    task automatic do_release();
        SEL = 16'hFFFF;
        tick();
        chk("busy_release_sample", int'(BUSY), 1);
        tick();
        chk("busy_after_release", int'(BUSY), 0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        CLRBAR = 1'b1;
        SEL    = 16'hFFFE;
        ACK    = 1'b0;

        // Reset held with a line asserted: nothing may be captured.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_valid", int'(VALID), 0);
            chk("rst_idx",   int'(IDX),   0);
            chk("rst_err",   int'(ERR),   0);
            chk("rst_busy",  int'(BUSY),  0);
        end
        CLRBAR = 1'b0;
        SEL    = 16'hFFFF;
        tick();
        tick();
        chk("idle_busy", int'(BUSY), 0);

        // Basic capture of line 5
        capture(~16'h0020, 4'h5, 1'b0);
        chk("hold_busy", int'(BUSY), 1);
        do_ack();
        do_release();

        // Glitch: line 0 for two cycles, then line 15 held
        SEL = ~16'h0001;
        tick();
        tick();
        capture(~16'h8000, 4'hF, 1'b0);
        do_ack();
        do_release();

        // ACK held high through qualification: ignored until HOLD
        ACK = 1'b1;
        capture(~16'h0200, 4'h9, 1'b0);
        tick();
        chk("early_ack_drop", int'(VALID), 0);
        ACK = 1'b0;
        do_release();

        // Hold and release: line stays asserted after ACK
        capture(~16'h0080, 4'h7, 1'b0);
        do_ack();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("held_no_valid", int'(VALID), 0);
            chk("held_busy",     int'(BUSY),  1);
        end
        do_release();
        capture(~16'h0080, 4'h7, 1'b0);
        do_ack();
        do_release();

        // Multi-hot: lines 2 and 4
        capture(~16'h0014, 4'h2, C_ERR_MULTI);
        do_ack();
        do_release();

        // Reset in QUAL (IDX currently 2 from the previous capture)
        SEL = ~16'h0400;
        tick();
        tick();
        chk("qual_busy", int'(BUSY), 1);
        CLRBAR = 1'b1;
        tick();
        chk("rstq_valid", int'(VALID), 0);
        chk("rstq_idx",   int'(IDX),   0);
        chk("rstq_busy",  int'(BUSY),  0);
        CLRBAR = 1'b0;
        capture(~16'h0400, 4'hA, 1'b0);

        // Reset in HOLD, then the held line qualifies again from scratch
        CLRBAR = 1'b1;
        tick();
        chk("rsth_valid", int'(VALID), 0);
        chk("rsth_idx",   int'(IDX),   0);
        chk("rsth_busy",  int'(BUSY),  0);
        CLRBAR = 1'b0;
        capture(~16'h0400, 4'hA, 1'b0);
        do_ack();
        do_release();

        tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule : tb_sel_encoder
`default_nettype wire
